// File: rtl/pwm_sequence_mode.sv
// Multi-phase PWM sequencer: each phase latches its own threshold/period/dwell and runs a stepped PWM counter.
// Optional output inversion is compiled in with macro PWM_SEQ_INVERT_EN (adds input invert_i).
module pwm_sequence_mode #(
    parameter int Resolution = 16,
    parameter int Phases     = 4,
    localparam int PhaseW    = $clog2(Phases)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         oneshot_i,
    input  logic [Phases*Resolution-1:0] threshold_i,
    input  logic [Phases*Resolution-1:0] period_i,
    input  logic [Phases*Resolution-1:0] duration_i,
    input  logic [Resolution-1:0]        step_i,
`ifdef PWM_SEQ_INVERT_EN
    input  logic                         invert_i,
`endif
    output logic                         pwm_o,
    output logic [PhaseW-1:0]            phase_o,
    output logic                         busy_o,
    output logic                         done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PhaseW-1:0] LastPhase = PhaseW'(Phases - 1);

    state_t                  state_q, state_d;
    logic [PhaseW-1:0]       phase_q, phase_d;
    logic [Resolution-1:0]   cnt_q, cnt_d;
    logic [Resolution-1:0]   dwell_q, dwell_d;
    logic [Resolution-1:0]   thr_q, thr_d;
    logic [Resolution-1:0]   per_q, per_d;
    logic [Resolution-1:0]   dur_q, dur_d;
    logic                    done_q, done_d;

    logic                    entry;
    logic [PhaseW-1:0]       entry_phase;
    logic [Resolution-1:0]   dwell_last;
    logic                    last_dwell;
    logic [Resolution:0]     sum;
    logic                    raw;

    // A zero duration still dwells for one cycle.
    assign dwell_last = (dur_q == '0) ? '0 : dur_q - 1'b1;
    assign last_dwell = (dwell_q == dwell_last);
    assign sum        = {1'b0, cnt_q} + {1'b0, step_i};

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        dwell_d     = dwell_q;
        thr_d       = thr_q;
        per_d       = per_q;
        dur_d       = dur_q;
        done_d      = 1'b0;
        entry       = 1'b0;
        entry_phase = '0;

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d     = RUN;
                    entry       = 1'b1;
                    entry_phase = '0;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    phase_d = '0;
                    cnt_d   = '0;
                    dwell_d = '0;
                end else if (last_dwell) begin
                    if (phase_q == LastPhase) begin
                        if (oneshot_i) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            cnt_d   = '0;
                            dwell_d = '0;
                        end else begin
                            entry       = 1'b1;
                            entry_phase = '0;
                        end
                    end else begin
                        entry       = 1'b1;
                        entry_phase = phase_q + PhaseW'(1);
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                    if (per_q == '0) begin
                        cnt_d = '0;
                    end else if (step_i == '0) begin
                        cnt_d = cnt_q;
                    end else if (sum >= {1'b0, per_q}) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = sum[Resolution-1:0];
                    end
                end
            end
            DONE: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                cnt_d   = '0;
                dwell_d = '0;
            end
        endcase

        // Phase entry: shadow this phase's settings and restart both counters.
        if (entry) begin
            phase_d = entry_phase;
            cnt_d   = '0;
            dwell_d = '0;
            thr_d   = threshold_i[int'(entry_phase)*Resolution +: Resolution];
            per_d   = period_i[int'(entry_phase)*Resolution +: Resolution];
            dur_d   = duration_i[int'(entry_phase)*Resolution +: Resolution];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            thr_q   <= '0;
            per_q   <= '0;
            dur_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            thr_q   <= thr_d;
            per_q   <= per_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
        end
    end

    assign raw = (cnt_q < thr_q);

`ifdef PWM_SEQ_INVERT_EN
    assign pwm_o = (state_q == RUN) && (raw ^ invert_i);
`else
    assign pwm_o = (state_q == RUN) && raw;
`endif

    assign phase_o = phase_q;
    assign busy_o  = (state_q == RUN);
    assign done_o  = done_q;

endmodule

// File: tb/tb_pwm_sequence_mode.sv
// Directed bench for pwm_sequence_mode (Resolution=8, Phases=2); driver pushes expected
// {pwm, phase, busy, done} per cycle, a negedge monitor pops and compares.
module tb_pwm_sequence_mode;

    localparam int Res = 8;
    localparam int Ph  = 2;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             oneshot;
    logic [Ph*Res-1:0] threshold;
    logic [Ph*Res-1:0] period;
    logic [Ph*Res-1:0] duration;
    logic [Res-1:0]   step;
    logic             pwm;
    logic             phase;
    logic             busy;
    logic             done;

    logic [3:0] exp_q[$];
    string      name_q[$];
    int         n_checks;
    int         n_fails;
    logic       end_chk;
    logic       end_done;
    logic [3:0] mon_exp;
    logic [3:0] mon_got;
    string      mon_name;

    pwm_sequence_mode #(
        .Resolution(Res),
        .Phases(Ph)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .enable_i(enable),
        .oneshot_i(oneshot),
        .threshold_i(threshold),
        .period_i(period),
        .duration_i(duration),
        .step_i(step),
        .pwm_o(pwm),
        .phase_o(phase),
        .busy_o(busy),
        .done_o(done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ev(input logic p, input logic ph, input logic b, input logic d);
        return {p, ph, b, d};
    endfunction

    // one clock: expectation for the outputs after the coming rising edge
    task automatic tick(input logic [3:0] e, input string n);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_got  = {pwm, phase, busy, done};
            n_checks = n_checks + 1;
            if (mon_got !== mon_exp) begin
                n_fails = n_fails + 1;
                $display("FAIL %s at %0t: got %b expected %b (pwm,phase,busy,done)",
                         mon_name, $time, mon_got, mon_exp);
            end
        end
        if (end_chk && !end_done) begin
            n_checks = n_checks + 1;
            if (exp_q.size() != 0) begin
                n_fails = n_fails + 1;
                $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            end
            end_done = 1'b1;
        end
    end

    logic [7:0] pat0;
    logic [7:0] pat1;

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        end_chk   = 1'b0;
        end_done  = 1'b0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        oneshot   = 1'b0;
        threshold = {8'd6, 8'd2};
        period    = {8'd8, 8'd4};
        duration  = {8'd8, 8'd8};
        step      = 8'd1;
        pat0      = 8'b11001100;
        pat1      = 8'b11111100;

        tick(ev(0, 0, 0, 0), "reset_hold");
        tick(ev(0, 0, 0, 0), "reset_hold");
        rst_n = 1'b1;
        tick(ev(0, 0, 0, 0), "idle_after_reset");

        // looping two-phase sequence
        enable = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) tick(ev(pat0[7-i], 0, 1, 0), "loop_ph0");
            for (int i = 0; i < 8; i++) tick(ev(pat1[7-i], 1, 1, 0), "loop_ph1");
        end
        enable = 1'b0;
        tick(ev(0, 0, 0, 0), "loop_disable");

        // one-shot, oneshot raised late: only the last-phase advance samples it
        enable = 1'b1;
        for (int i = 0; i < 8; i++) tick(ev(pat0[7-i], 0, 1, 0), "os_ph0");
        for (int i = 0; i < 8; i++) begin
            if (i == 2) oneshot = 1'b1;
            tick(ev(pat1[7-i], 1, 1, 0), "os_ph1");
        end
        tick(ev(0, 1, 0, 1), "os_done_pulse");
        for (int i = 0; i < 3; i++) tick(ev(0, 1, 0, 0), "os_done_hold");
        enable  = 1'b0;
        oneshot = 1'b0;
        tick(ev(0, 0, 0, 0), "os_idle");

        // step 3, period 10, threshold 5: cnt 0,3,6,9,0
        threshold = {8'd5, 8'd5};
        period    = {8'd10, 8'd10};
        step      = 8'd3;
        enable    = 1'b1;
        for (int i = 0; i < 16; i++) tick(ev(pat0[7-(i%8)], i / 8, 1, 0), "step3");
        enable = 1'b0;
        tick(ev(0, 0, 0, 0), "step3_idle");

        // thr >= per gives high, thr 0 gives low
        threshold = {8'd0, 8'd9};
        period    = {8'd8, 8'd8};
        duration  = {8'd4, 8'd4};
        step      = 8'd1;
        enable    = 1'b1;
        for (int i = 0; i < 4; i++) tick(ev(1, 0, 1, 0), "thr_over_per");
        for (int i = 0; i < 4; i++) tick(ev(0, 1, 1, 0), "thr_zero");
        enable = 1'b0;
        tick(ev(0, 0, 0, 0), "bound_idle");

        // period 0 and duration 0: phase advances every cycle
        threshold = {8'd0, 8'd1};
        period    = {8'd0, 8'd0};
        duration  = {8'd0, 8'd0};
        enable    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(ev(1, 0, 1, 0), "per0_thr1");
            tick(ev(0, 1, 1, 0), "dur0_ph1");
        end
        enable = 1'b0;
        tick(ev(0, 0, 0, 0), "dur0_idle");

        // step 0 holds the counter
        threshold = {8'd2, 8'd2};
        period    = {8'd4, 8'd4};
        duration  = {8'd4, 8'd4};
        step      = 8'd0;
        enable    = 1'b1;
        for (int i = 0; i < 4; i++) tick(ev(1, 0, 1, 0), "step0_hold");
        enable = 1'b0;
        tick(ev(0, 0, 0, 0), "step0_idle");

        // threshold change mid-phase waits for next entry; disable mid-phase
        threshold = {8'd6, 8'd2};
        period    = {8'd8, 8'd4};
        duration  = {8'd8, 8'd8};
        step      = 8'd1;
        enable    = 1'b1;
        for (int i = 0; i < 3; i++) tick(ev(pat0[7-i], 0, 1, 0), "shadow_pre");
        threshold = {8'd6, 8'd4};
        for (int i = 3; i < 8; i++) tick(ev(pat0[7-i], 0, 1, 0), "shadow_hold");
        for (int i = 0; i < 8; i++) tick(ev(pat1[7-i], 1, 1, 0), "shadow_ph1");
        for (int i = 0; i < 8; i++) tick(ev(1, 0, 1, 0), "shadow_new");
        for (int i = 0; i < 3; i++) tick(ev(pat1[7-i], 1, 1, 0), "abort_ph1");
        enable = 1'b0;
        tick(ev(0, 0, 0, 0), "abort_idle");
        tick(ev(0, 0, 0, 0), "abort_no_done");

        // asynchronous reset between edges
        threshold = {8'd6, 8'd2};
        enable    = 1'b1;
        tick(ev(1, 0, 1, 0), "pre_async");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.push_back(ev(0, 0, 0, 0));
        name_q.push_back("async_reset");
        tick(ev(0, 0, 0, 0), "reset_held");
        rst_n = 1'b1;
        tick(ev(1, 0, 1, 0), "rerun_c0");
        tick(ev(1, 0, 1, 0), "rerun_c1");
        tick(ev(0, 0, 1, 0), "rerun_c2");
        enable = 1'b0;
        tick(ev(0, 0, 0, 0), "rerun_idle");

        @(negedge clk);
        #1;
        end_chk = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pwm_sequence_mode.md
PWM_SEQUENCE_MODE -- requirements
Module: pwm_sequence_mode

Interface
REQ-001 SHALL have parameter Resolution, default 16, width of all counters, thresholds, periods, durations and step.
REQ-002 SHALL have parameter Phases, default 4, number of sequence phases (legal 2..16); PhaseW = $clog2(Phases).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port enable_i  input  1  level; high runs the sequence, low returns to IDLE.
REQ-006 SHALL have port oneshot_i  input  1  high: stop after last phase; low: loop forever.
REQ-007 SHALL have port threshold_i  input  Phases*Resolution  per-phase high time; phase k at bits [k*Resolution +: Resolution].
REQ-008 SHALL have port period_i  input  Phases*Resolution  per-phase PWM period, same packing.
REQ-009 SHALL have port duration_i  input  Phases*Resolution  per-phase dwell in clk_i cycles, same packing.
REQ-010 SHALL have port step_i  input  Resolution  PWM counter increment per cycle.
REQ-011 SHALL have port pwm_o  output  1  PWM output.
REQ-012 SHALL have port phase_o  output  PhaseW  index of current phase.
REQ-013 SHALL have port busy_o  output  1  high in RUN.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse on one-shot completion.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN when enable_i=1; any state->IDLE on the cycle after enable_i=0 is sampled.
REQ-016 SHALL, on each phase entry (IDLE->RUN and every phase advance), latch that phase's threshold, period and duration into shadow registers; input changes take effect only at the next phase entry.
REQ-017 SHALL clear the PWM counter and dwell counter to 0 on each phase entry.
REQ-018 SHALL in RUN update PWM counter as: sum = cnt + step_i in Resolution+1 bits; if sum >= shadow period then cnt <= 0, else cnt <= sum[Resolution-1:0].
REQ-019 SHALL drive pwm_o = (state==RUN) && (cnt < shadow threshold), combinational from registers only; threshold >= period gives constant high, threshold 0 gives constant low.
REQ-020 SHALL hold cnt at 0 when shadow period is 0 (pwm_o = threshold != 0) and hold cnt unchanged when step_i is 0.
REQ-021 SHALL advance phase when dwell counter equals max(shadow duration,1)-1; duration 0 is treated as 1 cycle.
REQ-022 SHALL on advance from phase Phases-1: with oneshot_i=0 wrap to phase 0 and stay in RUN; with oneshot_i=1 enter DONE and assert done_o for exactly that one transition cycle.
REQ-023 SHALL in DONE drive pwm_o=0, busy_o=0, phase_o=Phases-1 until enable_i=0.
REQ-024 SHALL sample oneshot_i only at the last-phase advance.
REQ-025 SHALL in IDLE hold phase_o=0, counters 0, pwm_o=0.

Reset
REQ-026 SHALL on rst_ni=0 asynchronously force state IDLE, all counters and shadows 0, pwm_o=0, phase_o=0, busy_o=0, done_o=0.
REQ-027 SHALL after reset release require enable_i=1 to be sampled before entering RUN; reset mid-sequence abandons it with no done_o.

Configuration
REQ-028 SHALL support macro PWM_SEQ_INVERT_EN: when defined, add input invert_i (1 bit) and drive pwm_o = raw ^ invert_i in RUN only (IDLE/DONE still 0); when undefined, no invert_i port and pwm_o = raw.

Verification
REQ-029 Resolution=8, Phases=2, thr={2,6}, per={4,8}, dur={8,8}, step=1, loop -> pwm_o 1100 1100 then 11111100, phase_o toggles every 8 cycles, repeats.
REQ-030 Same config, oneshot_i=1 -> after 16 RUN cycles done_o high exactly 1 cycle, then pwm_o=0, busy_o=0, phase_o=1 until enable_i=0.
REQ-031 per=10, step=3, thr=5 -> cnt 0,3,6,9,0; pwm_o 1,1,0,0 repeating.
REQ-032 thr=9, per=8 -> pwm_o constant 1; thr=0 -> constant 0; per=0, thr=1 -> constant 1; dur=0 -> phase advances every cycle.
REQ-033 Change thr of active phase mid-phase -> pwm_o unchanged until next phase entry; drop enable_i mid-phase -> IDLE next cycle, pwm_o=0, no done_o.
REQ-034 Assert rst_ni=0 between clock edges mid-RUN -> outputs 0 immediately without a clock edge.
